// File: rtl/vscale_dmem_responder_if.sv
// Core-side data-memory port plus backing-memory request/response channel
// bundled for vscale_dmem_responder; slave is the responder's view.
interface vscale_dmem_responder_if;
    logic        dmem_en;
    logic        dmem_wen;
    logic [2:0]  dmem_size;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_wait;
    logic        dmem_badmem_e;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [29:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    modport master (
        output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_wait, dmem_badmem_e,
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_be,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_wait, dmem_badmem_e,
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_be,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/vscale_dmem_responder.sv
// Translates vscale core data-memory accesses into word-wide backing requests.
// Optional abort of stuck backing accesses is enabled by VSCALE_DMEM_TIMEOUT_EN.
module vscale_dmem_responder #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                     clk,
    input logic                     reset_n,
    vscale_dmem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t      state;
    logic [29:0] word_addr_q;
    logic [1:0]  lane_q;
    logic        wen_q;
    logic [2:0]  size_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        first_q;

    logic        store_done;
    logic        load_handshake;
    logic        load_done;
    logic        stall;
    logic        accept;
    logic        bad_req;
    logic        timeout_hit;
    logic [3:0]  be_next;
    logic [31:0] store_word;
    logic [31:0] store_rep;
    logic [31:0] rsp_shifted;
    logic [31:0] load_ext;

    assign store_done     = (state == ISSUE) && wen_q && bus.mem_req_ready;
    assign load_handshake = (state == ISSUE) && !wen_q && bus.mem_req_ready;
    assign load_done      = (state == RESP) && bus.mem_rsp_valid;
    assign stall          = ((state == ISSUE) && !store_done) ||
                            ((state == RESP) && !load_done);
    assign accept         = bus.dmem_en && !stall;

`ifdef VSCALE_DMEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;

    // A handshake in the final cycle still counts as progress, not a timeout.
    assign timeout_hit = (wait_cnt == TIMEOUT_LAST) &&
                         (((state == ISSUE) && !bus.mem_req_ready) ||
                          ((state == RESP) && !bus.mem_rsp_valid));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        bad_req = 1'b0;
        case (bus.dmem_size)
            3'd0, 3'd4: bad_req = 1'b0;
            3'd1, 3'd5: bad_req = bus.dmem_addr[0];
            3'd2:       bad_req = (bus.dmem_addr[1:0] != 2'b00);
            default:    bad_req = 1'b1;
        endcase
    end

    always_comb begin
        be_next = 4'b0000;
        case (bus.dmem_size[1:0])
            2'd0:    be_next = 4'b0001 << bus.dmem_addr[1:0];
            2'd1:    be_next = 4'b0011 << bus.dmem_addr[1:0];
            2'd2:    be_next = 4'b1111;
            default: be_next = 4'b0000;
        endcase
    end

    // Store data only becomes valid in the first ISSUE cycle, so it is used
    // directly then and taken from the register afterwards.
    assign store_word = first_q ? bus.dmem_wdata : wdata_q;

    always_comb begin
        store_rep = store_word;
        case (size_q[1:0])
            2'd0:    store_rep = {4{store_word[7:0]}};
            2'd1:    store_rep = {2{store_word[15:0]}};
            default: store_rep = store_word;
        endcase
    end

    assign rsp_shifted = bus.mem_rsp_rdata >> {lane_q, 3'b000};

    always_comb begin
        load_ext = rsp_shifted;
        case (size_q)
            3'd0:    load_ext = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
            3'd1:    load_ext = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
            3'd4:    load_ext = {24'd0, rsp_shifted[7:0]};
            3'd5:    load_ext = {16'd0, rsp_shifted[15:0]};
            default: load_ext = rsp_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            word_addr_q <= '0;
            lane_q      <= '0;
            wen_q       <= 1'b0;
            size_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            first_q     <= 1'b0;
`ifdef VSCALE_DMEM_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            if ((state == ISSUE) && first_q) begin
                wdata_q <= bus.dmem_wdata;
            end
`ifdef VSCALE_DMEM_TIMEOUT_EN
            if ((state == ISSUE) || (state == RESP)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
`endif
            // A new request wins over every other transition: completion
            // cycles and ERR hand straight over to the next access.
            if (accept) begin
                word_addr_q <= bus.dmem_addr[31:2];
                lane_q      <= bus.dmem_addr[1:0];
                wen_q       <= bus.dmem_wen;
                size_q      <= bus.dmem_size;
                be_q        <= be_next;
                first_q     <= !bad_req;
                state       <= bad_req ? ERR : ISSUE;
`ifdef VSCALE_DMEM_TIMEOUT_EN
                wait_cnt    <= '0;
`endif
            end else begin
                case (state)
                    ISSUE: begin
                        first_q <= 1'b0;
                        if (load_handshake) begin
                            state <= RESP;
                        end else if (store_done) begin
                            state <= IDLE;
                        end else if (timeout_hit) begin
                            state <= ERR;
                        end
                    end
                    RESP: begin
                        if (load_done) begin
                            state <= IDLE;
                        end else if (timeout_hit) begin
                            state <= ERR;
                        end
                    end
                    ERR:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.dmem_wait     = stall;
    assign bus.dmem_badmem_e = (state == ERR);
    assign bus.dmem_rdata    = (load_done && !wen_q) ? load_ext : 32'd0;

    assign bus.mem_req_valid = (state == ISSUE);
    assign bus.mem_req_wen   = (state == ISSUE) && wen_q;
    assign bus.mem_req_addr  = (state == ISSUE) ? word_addr_q : 30'd0;
    assign bus.mem_req_be    = (state == ISSUE) ? be_q : 4'd0;
    assign bus.mem_req_wdata = ((state == ISSUE) && wen_q) ? store_rep : 32'd0;

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Directed-vector bench for vscale_dmem_responder with hand-computed results;
// the timeout scenario runs only when VSCALE_DMEM_TIMEOUT_EN is defined.
module tb_vscale_dmem_responder;

    logic clk = 1'b0;
    logic reset_n;
    int   vector_count = 0;
    int   miscompare_count = 0;

    vscale_dmem_responder_if bus();

    vscale_dmem_responder #(.TIMEOUT_CYCLES(255)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vector_count++;
        if (got !== exp) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic wen, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        bus.dmem_en    = en;
        bus.dmem_wen   = wen;
        bus.dmem_size  = size;
        bus.dmem_addr  = addr;
        bus.dmem_wdata = wdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Accept, one ISSUE cycle with ready, one RESP stall cycle, then response.
    task automatic do_load(input string tag, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] rsp, input logic [31:0] exp);
        applyStimulus(1'b1, 1'b0, size, addr, 32'd0);
        bus.mem_req_ready = 1'b1;
        #3;
        checkOutput({tag, " accept wait"}, bus.dmem_wait, 32'd0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #3;
        checkOutput({tag, " issue valid"}, bus.mem_req_valid, 32'd1);
        checkOutput({tag, " issue addr"}, bus.mem_req_addr, {2'b00, addr[31:2]});
        checkOutput({tag, " issue wen"}, bus.mem_req_wen, 32'd0);
        checkOutput({tag, " issue wait"}, bus.dmem_wait, 32'd1);
        next_cycle();
        bus.mem_req_ready = 1'b0;
        #3;
        checkOutput({tag, " resp wait"}, bus.dmem_wait, 32'd1);
        checkOutput({tag, " resp valid"}, bus.mem_req_valid, 32'd0);
        checkOutput({tag, " resp rdata idle"}, bus.dmem_rdata, 32'd0);
        next_cycle();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = rsp;
        #3;
        checkOutput({tag, " rsp wait"}, bus.dmem_wait, 32'd0);
        checkOutput({tag, " rsp rdata"}, bus.dmem_rdata, exp);
        next_cycle();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'd0;
    endtask

    // Misaligned or illegal request: one ERR cycle, nothing reaches memory.
    task automatic do_error(input string tag, input logic wen, input logic [2:0] size,
                            input logic [31:0] addr);
        applyStimulus(1'b1, wen, size, addr, 32'd0);
        #3;
        checkOutput({tag, " accept valid"}, bus.mem_req_valid, 32'd0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #3;
        checkOutput({tag, " badmem"}, bus.dmem_badmem_e, 32'd1);
        checkOutput({tag, " err wait"}, bus.dmem_wait, 32'd0);
        checkOutput({tag, " err valid"}, bus.mem_req_valid, 32'd0);
        next_cycle();
        #3;
        checkOutput({tag, " badmem drop"}, bus.dmem_badmem_e, 32'd0);
        checkOutput({tag, " after valid"}, bus.mem_req_valid, 32'd0);
        next_cycle();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'd0;
        #3;
        checkOutput("reset wait", bus.dmem_wait, 32'd0);
        checkOutput("reset badmem", bus.dmem_badmem_e, 32'd0);
        checkOutput("reset valid", bus.mem_req_valid, 32'd0);
        checkOutput("reset rdata", bus.dmem_rdata, 32'd0);
        checkOutput("reset be", bus.mem_req_be, 32'd0);
        #20;
        reset_n = 1'b1;
        next_cycle();

        do_load("LW 100", 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load("LB 103", 3'd0, 32'h0000_0103, 32'h80FF_FFFF, 32'hFFFF_FF80);
        do_load("LBU 103", 3'd4, 32'h0000_0103, 32'h80FF_FFFF, 32'h0000_0080);
        do_load("LHU 102", 3'd5, 32'h0000_0102, 32'h80FF_FFFF, 32'h0000_80FF);
        do_load("LH 102", 3'd1, 32'h0000_0102, 32'h80FF_FFFF, 32'hFFFF_80FF);
        do_load("LB 101", 3'd0, 32'h0000_0101, 32'h1234_5678, 32'h0000_0056);

        // Stray response while idle is ignored.
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h5555_5555;
        #3;
        checkOutput("idle rsp rdata", bus.dmem_rdata, 32'd0);
        checkOutput("idle rsp wait", bus.dmem_wait, 32'd0);
        next_cycle();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'd0;

        // SH 0x102 with ready held low for three cycles.
        applyStimulus(1'b1, 1'b1, 3'd1, 32'h0000_0102, 32'd0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'h0000_1234);
        for (int i = 0; i < 3; i++) begin
            #3;
            checkOutput("SH valid", bus.mem_req_valid, 32'd1);
            checkOutput("SH wen", bus.mem_req_wen, 32'd1);
            checkOutput("SH addr", bus.mem_req_addr, 32'h0000_0040);
            checkOutput("SH be", bus.mem_req_be, 32'h0000_000C);
            checkOutput("SH wdata", bus.mem_req_wdata, 32'h1234_1234);
            checkOutput("SH wait", bus.dmem_wait, 32'd1);
            next_cycle();
            // Stalled request with garbage data: must be ignored.
            applyStimulus(1'b1, 1'b0, 3'd3, 32'h0000_0001, 32'hFFFF_FFFF);
        end
        bus.mem_req_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h0000_0200, 32'hFFFF_FFFF);
        #3;
        checkOutput("SH done wait", bus.dmem_wait, 32'd0);
        checkOutput("SH done wdata", bus.mem_req_wdata, 32'h1234_1234);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #3;
        checkOutput("b2b LW valid", bus.mem_req_valid, 32'd1);
        checkOutput("b2b LW wen", bus.mem_req_wen, 32'd0);
        checkOutput("b2b LW addr", bus.mem_req_addr, 32'h0000_0080);
        checkOutput("b2b LW be", bus.mem_req_be, 32'h0000_000F);
        checkOutput("b2b LW badmem", bus.dmem_badmem_e, 32'd0);
        next_cycle();
        bus.mem_req_ready = 1'b0;
        #3;
        checkOutput("b2b LW resp wait", bus.dmem_wait, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("mid reset wait", bus.dmem_wait, 32'd0);
        checkOutput("mid reset valid", bus.mem_req_valid, 32'd0);
        #2;
        reset_n = 1'b1;
        next_cycle();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'hDEAD_BEEF;
        #3;
        checkOutput("late rsp rdata", bus.dmem_rdata, 32'd0);
        checkOutput("late rsp wait", bus.dmem_wait, 32'd0);
        next_cycle();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'd0;

        // SB 0x101 completing in its first ISSUE cycle.
        applyStimulus(1'b1, 1'b1, 3'd0, 32'h0000_0101, 32'd0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'h0000_00AB);
        bus.mem_req_ready = 1'b1;
        #3;
        checkOutput("SB be", bus.mem_req_be, 32'h0000_0002);
        checkOutput("SB wdata", bus.mem_req_wdata, 32'hABAB_ABAB);
        checkOutput("SB wait", bus.dmem_wait, 32'd0);
        next_cycle();
        bus.mem_req_ready = 1'b0;
        #3;
        checkOutput("SB after valid", bus.mem_req_valid, 32'd0);
        next_cycle();

        // SW 0x104, word passes through unchanged.
        applyStimulus(1'b1, 1'b1, 3'd2, 32'h0000_0104, 32'd0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'hCAFE_F00D);
        bus.mem_req_ready = 1'b1;
        #3;
        checkOutput("SW be", bus.mem_req_be, 32'h0000_000F);
        checkOutput("SW wdata", bus.mem_req_wdata, 32'hCAFE_F00D);
        checkOutput("SW addr", bus.mem_req_addr, 32'h0000_0041);
        next_cycle();
        bus.mem_req_ready = 1'b0;

        do_error("LW 101", 1'b0, 3'd2, 32'h0000_0101);
        do_error("size 3", 1'b0, 3'd3, 32'h0000_0100);
        do_error("SH 101", 1'b1, 3'd1, 32'h0000_0101);
        do_error("size 7", 1'b0, 3'd7, 32'h0000_0100);

        // Request presented during ERR is accepted without a bubble.
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h0000_0102, 32'd0);
        next_cycle();
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h0000_0104, 32'd0);
        #3;
        checkOutput("ERR b2b badmem", bus.dmem_badmem_e, 32'd1);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #3;
        checkOutput("ERR b2b valid", bus.mem_req_valid, 32'd1);
        checkOutput("ERR b2b addr", bus.mem_req_addr, 32'h0000_0041);
        bus.mem_req_ready = 1'b1;
        next_cycle();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h0BAD_CAFE;
        #3;
        checkOutput("ERR b2b rdata", bus.dmem_rdata, 32'h0BAD_CAFE);
        next_cycle();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'd0;

`ifdef VSCALE_DMEM_TIMEOUT_EN
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h0000_0300, 32'd0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        for (int i = 0; i < 255; i++) begin
            #3;
            if (bus.mem_req_valid !== 1'b1) begin
                checkOutput("timeout early drop", bus.mem_req_valid, 32'd1);
            end
            next_cycle();
        end
        #3;
        checkOutput("timeout badmem", bus.dmem_badmem_e, 32'd1);
        checkOutput("timeout valid", bus.mem_req_valid, 32'd0);
        next_cycle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule

// File: doc/vscale_dmem_responder.md
VSCALE_DMEM_RESPONDER -- requirements
Module: vscale_dmem_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles before an unanswered backing access is aborted; 8-bit maximum; used only with VSCALE_DMEM_TIMEOUT_EN.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port dmem_en  in  1  core request strobe.
REQ-005 SHALL have port dmem_wen  in  1  1 = store, 0 = load.
REQ-006 SHALL have port dmem_size  in  3  funct3 code: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
REQ-007 SHALL have port dmem_addr  in  32  byte address.
REQ-008 SHALL have port dmem_wdata  in  32  store data, valid in the cycle after acceptance.
REQ-009 SHALL have port dmem_rdata  out  32  extended load data.
REQ-010 SHALL have port dmem_wait  out  1  stall to core.
REQ-011 SHALL have port dmem_badmem_e  out  1  access error pulse.
REQ-012 SHALL have port mem_req_valid  out  1  backing request valid.
REQ-013 SHALL have port mem_req_ready  in  1  backing request accepted.
REQ-014 SHALL have port mem_req_wen  out  1  backing write.
REQ-015 SHALL have port mem_req_addr  out  30  word address (dmem_addr[31:2]).
REQ-016 SHALL have port mem_req_wdata  out  32  lane-replicated store data.
REQ-017 SHALL have port mem_req_be  out  4  byte enables.
REQ-018 SHALL have port mem_rsp_valid  in  1  load response valid, one cycle.
REQ-019 SHALL have port mem_rsp_rdata  in  32  load response word.

Function
REQ-020 SHALL implement states IDLE, ISSUE, RESP, ERR.
REQ-021 SHALL accept a request when dmem_en=1 and dmem_wait=0, capturing addr, wen and size.
REQ-022 SHALL go to ERR on acceptance if size is 3, 6 or 7, if a halfword access has addr[0]=1, or if a word access has addr[1:0]!=0; otherwise SHALL go to ISSUE.
REQ-023 ERR: dmem_badmem_e=1 and dmem_wait=0 for exactly one cycle; no backing request issued; next state IDLE, or a newly accepted request.
REQ-024 ISSUE: mem_req_valid=1 and dmem_wait=1; dmem_wdata SHALL be registered on the first ISSUE cycle; all mem_req_* outputs SHALL be held stable until mem_req_ready=1.
REQ-025 be SHALL be 0001<<addr[1:0] for bytes, 0011<<addr[1:0] for halfwords, and 1111 for words; wdata SHALL be the byte replicated 4x, the halfword replicated 2x, or the word unchanged.
REQ-026 A store handshake (ISSUE and mem_req_ready=1) SHALL drop dmem_wait combinationally in that cycle and complete the store.
REQ-027 A load handshake SHALL move ISSUE to RESP; RESP SHALL hold dmem_wait=1 until mem_rsp_valid=1.
REQ-028 In the mem_rsp_valid cycle, dmem_wait SHALL be 0 and dmem_rdata SHALL be the addressed lane, sign-extended for sizes 0/1 and zero-extended for sizes 4/5.
REQ-029 In any completion cycle (store handshake, load response, ERR), a simultaneous dmem_en=1 SHALL be accepted, giving back-to-back operation with no bubble.
REQ-030 dmem_en while dmem_wait=1 SHALL be ignored.
REQ-031 mem_rsp_valid outside RESP SHALL be ignored.
REQ-032 dmem_rdata SHALL be 0 whenever no load response is presented.

Reset
REQ-033 reset_n low SHALL force IDLE immediately, including in the middle of an operation, with all outputs 0; captured registers SHALL be 0.
REQ-034 A backing response arriving after reset releases SHALL be ignored.

Configuration
REQ-035 With VSCALE_DMEM_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to ISSUE and increment in ISSUE/RESP; on reaching TIMEOUT_CYCLES without completion, the block SHALL drop mem_req_valid and enter ERR. Without the macro, there SHALL be no counter and waits SHALL be unbounded.

Verification
REQ-036 LW addr 0x100, ready=1, rsp 1 cycle later with 0xDEADBEEF -> dmem_wait=1 for 2 cycles, then rdata=0xDEADBEEF.
REQ-037 LB addr 0x103, rsp 0x80FF_FFFF -> rdata=0xFFFFFF80; LBU -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
REQ-038 SH addr 0x102, wdata 0x1234 -> be=1100, mem_req_wdata=0x12341234, ready held low 3 cycles -> request stable and wait=1 throughout.
REQ-039 LW addr 0x101 -> badmem_e=1 for one cycle, mem_req_valid never asserted; size=3 -> same.
REQ-040 Store completion with a concurrent LW -> LW issues the next cycle; reset_n pulsed in RESP -> IDLE, and a late rsp has no effect.
REQ-041 With VSCALE_DMEM_TIMEOUT_EN, ready held 0 -> badmem_e pulses after 255 cycles.
